// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants up to WB_PORTS functional-unit results per cycle in round-robin order
// and drives them to the PRF write ports, the wakeup broadcast and ROB completion one cycle later.
module wb_arbiter #(
  parameter int FU_COUNT     = 4,
  parameter int WB_PORTS     = 2,
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int FUC_BITS     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    fu_wb_valid      [FU_COUNT],
  input  logic [INST_ID_BITS-1:0] fu_wb_inst_id    [FU_COUNT],
  input  logic                    fu_wb_prn_valid  [FU_COUNT],
  input  logic [PRN_BITS-1:0]     fu_wb_prn        [FU_COUNT],
  input  logic [63:0]             fu_wb_data       [FU_COUNT],
  output logic                    fu_wb_ready      [FU_COUNT],
  output logic                    wb_valid         [WB_PORTS],
  output logic [INST_ID_BITS-1:0] wb_inst_id       [WB_PORTS],
  output logic [FUC_BITS-1:0]     wb_fu            [WB_PORTS],
  output logic                    prf_write_enable [WB_PORTS],
  output logic [PRN_BITS-1:0]     prf_write_prn    [WB_PORTS],
  output logic [63:0]             prf_write_data   [WB_PORTS],
  output logic                    set_prn_ready    [WB_PORTS]
);

  logic [FUC_BITS-1:0] rr_ptr;
  logic [FUC_BITS-1:0] rr_next;
  logic                any_grant;
  logic                port_en  [WB_PORTS];
  logic [FUC_BITS-1:0] port_sel [WB_PORTS];

  // Scan from rr_ptr; the k-th requester found lands on port k.
  always_comb begin
    int                  cnt;
    logic [FUC_BITS:0]   idx;
    logic [FUC_BITS-1:0] last;
    cnt       = 0;
    idx       = '0;
    last      = '0;
    any_grant = 1'b0;
    for (int i = 0; i < FU_COUNT; i++) fu_wb_ready[i] = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      port_en[p]  = 1'b0;
      port_sel[p] = '0;
    end
    for (int j = 0; j < FU_COUNT; j++) begin
      idx = {1'b0, rr_ptr} + (FUC_BITS+1)'(j);
      if (idx >= (FUC_BITS+1)'(FU_COUNT)) idx = idx - (FUC_BITS+1)'(FU_COUNT);
      if (!rst && !flush && fu_wb_valid[idx[FUC_BITS-1:0]] && cnt < WB_PORTS) begin
        fu_wb_ready[idx[FUC_BITS-1:0]] = 1'b1;
        for (int p = 0; p < WB_PORTS; p++) begin
          if (p == cnt) begin
            port_en[p]  = 1'b1;
            port_sel[p] = idx[FUC_BITS-1:0];
          end
        end
        last      = idx[FUC_BITS-1:0];
        any_grant = 1'b1;
        cnt       = cnt + 1;
      end
    end
    rr_next = (last == FUC_BITS'(FU_COUNT-1)) ? '0 : last + FUC_BITS'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      for (int p = 0; p < WB_PORTS; p++) begin
        wb_valid[p]         <= 1'b0;
        prf_write_enable[p] <= 1'b0;
        wb_inst_id[p]       <= '0;
        wb_fu[p]            <= '0;
        prf_write_prn[p]    <= '0;
        prf_write_data[p]   <= '0;
      end
    end else begin
      if (any_grant) rr_ptr <= rr_next;
      for (int p = 0; p < WB_PORTS; p++) begin
        wb_valid[p]         <= port_en[p];
        prf_write_enable[p] <= port_en[p] && fu_wb_prn_valid[port_sel[p]];
        // Idle ports keep stale payload; consumers qualify on wb_valid.
        if (port_en[p]) begin
          wb_inst_id[p]     <= fu_wb_inst_id[port_sel[p]];
          wb_fu[p]          <= port_sel[p];
          prf_write_prn[p]  <= fu_wb_prn[port_sel[p]];
          prf_write_data[p] <= fu_wb_data[port_sel[p]];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) set_prn_ready[p] = prf_write_enable[p];
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a queue-based round-robin model.
module tb_wb_arbiter;
  localparam int NF = 4;
  localparam int NP = 2;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        fu_wb_valid      [NF];
  logic [5:0]  fu_wb_inst_id    [NF];
  logic        fu_wb_prn_valid  [NF];
  logic [5:0]  fu_wb_prn        [NF];
  logic [63:0] fu_wb_data       [NF];
  logic        fu_wb_ready      [NF];
  logic        wb_valid         [NP];
  logic [5:0]  wb_inst_id       [NP];
  logic [1:0]  wb_fu            [NP];
  logic        prf_write_enable [NP];
  logic [5:0]  prf_write_prn    [NP];
  logic [63:0] prf_write_data   [NP];
  logic        set_prn_ready    [NP];

  wb_arbiter #(.FU_COUNT(NF), .WB_PORTS(NP), .INST_ID_BITS(6), .PRN_BITS(6), .FUC_BITS(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_wb_valid(fu_wb_valid), .fu_wb_inst_id(fu_wb_inst_id), .fu_wb_prn_valid(fu_wb_prn_valid),
    .fu_wb_prn(fu_wb_prn), .fu_wb_data(fu_wb_data), .fu_wb_ready(fu_wb_ready),
    .wb_valid(wb_valid), .wb_inst_id(wb_inst_id), .wb_fu(wb_fu),
    .prf_write_enable(prf_write_enable), .prf_write_prn(prf_write_prn),
    .prf_write_data(prf_write_data), .set_prn_ready(set_prn_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // model state
  int          m_rr;
  bit          exp_ready [NF];
  int          g_fu [NP];
  int          g_n;
  bit          e_valid [NP];
  bit          e_pen   [NP];
  logic [5:0]  e_id    [NP];
  logic [1:0]  e_fu    [NP];
  logic [5:0]  e_prn   [NP];
  logic [63:0] e_data  [NP];
  int          wait_cnt [NF];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requesters in scan order from m_rr; the first NP of them win.
  task automatic compute_grants();
    int req[$];
    req = {};
    for (int i = 0; i < NF; i++) exp_ready[i] = 1'b0;
    if (!rst && !flush)
      for (int j = 0; j < NF; j++)
        if (fu_wb_valid[(m_rr + j) % NF]) req.push_back((m_rr + j) % NF);
    g_n = (req.size() < NP) ? req.size() : NP;
    for (int k = 0; k < g_n; k++) begin
      g_fu[k] = req[k];
      exp_ready[req[k]] = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_rr = 0;
    for (int p = 0; p < NP; p++) begin
      e_valid[p] = 0; e_pen[p] = 0;
      e_id[p] = '0; e_fu[p] = '0; e_prn[p] = '0; e_data[p] = '0;
    end
    for (int i = 0; i < NF; i++) wait_cnt[i] = 0;
  endtask

  // One clock: compare at negedge, advance model, return at posedge+1.
  task automatic step();
    @(negedge clk);
    compute_grants();
    for (int i = 0; i < NF; i++) chk($sformatf("ready[%0d]", i), 64'(fu_wb_ready[i]), 64'(exp_ready[i]));
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("wb_valid[%0d]", p), 64'(wb_valid[p]), 64'(e_valid[p]));
      chk($sformatf("prf_we[%0d]", p), 64'(prf_write_enable[p]), 64'(e_pen[p]));
      chk($sformatf("set_prn_ready[%0d]", p), 64'(set_prn_ready[p]), 64'(e_pen[p]));
      if (e_valid[p]) begin
        chk($sformatf("wb_inst_id[%0d]", p), 64'(wb_inst_id[p]), 64'(e_id[p]));
        chk($sformatf("wb_fu[%0d]", p), 64'(wb_fu[p]), 64'(e_fu[p]));
        chk($sformatf("prf_prn[%0d]", p), 64'(prf_write_prn[p]), 64'(e_prn[p]));
        chk($sformatf("prf_data[%0d]", p), prf_write_data[p], e_data[p]);
      end
    end
    for (int i = 0; i < NF; i++) begin
      if (!fu_wb_valid[i]) wait_cnt[i] = 0;
      else if (!flush && !rst) begin
        if (exp_ready[i]) begin
          chk($sformatf("fairness[%0d]", i), 64'(wait_cnt[i] <= (NF + NP - 1) / NP - 1), 64'd1);
          wait_cnt[i] = 0;
        end else wait_cnt[i]++;
      end
    end
    for (int p = 0; p < NP; p++) begin
      e_valid[p] = (p < g_n);
      e_pen[p]   = 0;
      if (p < g_n) begin
        e_pen[p]  = fu_wb_prn_valid[g_fu[p]];
        e_id[p]   = fu_wb_inst_id[g_fu[p]];
        e_fu[p]   = 2'(g_fu[p]);
        e_prn[p]  = fu_wb_prn[g_fu[p]];
        e_data[p] = fu_wb_data[g_fu[p]];
      end
    end
    if (g_n > 0) m_rr = (g_fu[g_n-1] + 1) % NF;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input bit v, input logic [5:0] id, input bit pv,
                        input logic [5:0] prn, input logic [63:0] dat);
    fu_wb_valid[i] = v; fu_wb_inst_id[i] = id; fu_wb_prn_valid[i] = pv;
    fu_wb_prn[i] = prn; fu_wb_data[i] = dat;
  endtask

  task automatic new_req(input int i);
    set_fu(i, 1'b1, 6'($urandom), 1'($urandom), 6'($urandom), {$urandom, $urandom});
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    model_reset();
    for (int i = 0; i < NF; i++) set_fu(i, 1'b1, 6'(10 + i), 1'b1, 6'(20 + i), 64'h1000 + 64'(i));

    // reset state, requests held during reset must not be granted
    @(posedge clk); #1;
    chk("rst_ready0", 64'(fu_wb_ready[0]), 64'd0);
    chk("rst_wb_valid0", 64'(wb_valid[0]), 64'd0);
    chk("rst_prf_data1", prf_write_data[1], 64'd0);
    chk("rst_wb_fu1", 64'(wb_fu[1]), 64'd0);
    step();
    rst = 1'b0;

    // all four valid: FU0,FU1 then FU2,FU3
    step();
    chk("t1_port0_id", 64'(wb_inst_id[0]), 64'd10);
    chk("t1_port0_data", prf_write_data[0], 64'h1000);
    chk("t1_port1_fu", 64'(wb_fu[1]), 64'd1);
    fu_wb_valid[0] = 1'b0; fu_wb_valid[1] = 1'b0;
    step();
    chk("t1_c1_fu0", 64'(wb_fu[0]), 64'd2);
    chk("t1_c1_fu1", 64'(wb_fu[1]), 64'd3);
    // pointer wrapped to 0: FU1 scans ahead of FU3
    set_fu(0, 0, 0, 0, 0, 0); set_fu(2, 0, 0, 0, 0, 0);
    set_fu(1, 1, 6'd33, 1, 6'd9, 64'h11); set_fu(3, 1, 6'd34, 1, 6'd8, 64'h33);
    step();
    chk("t1_wrap_fu0", 64'(wb_fu[0]), 64'd1);
    chk("t1_wrap_fu1", 64'(wb_fu[1]), 64'd3);

    // single requester FU3
    for (int i = 0; i < NF; i++) fu_wb_valid[i] = 1'b0;
    set_fu(3, 1, 6'd44, 1, 6'd5, 64'hDEAD);
    step();
    chk("t2_valid0", 64'(wb_valid[0]), 64'd1);
    chk("t2_prn0", 64'(prf_write_prn[0]), 64'd5);
    chk("t2_setprn0", 64'(set_prn_ready[0]), 64'd1);
    chk("t2_data0", prf_write_data[0], 64'hDEAD);
    chk("t2_valid1", 64'(wb_valid[1]), 64'd0);

    // FU2 without a destination register
    fu_wb_valid[3] = 1'b0;
    set_fu(2, 1, 6'd7, 0, 6'd12, 64'h77);
    step();
    chk("t3_valid0", 64'(wb_valid[0]), 64'd1);
    chk("t3_we0", 64'(prf_write_enable[0]), 64'd0);
    chk("t3_setprn0", 64'(set_prn_ready[0]), 64'd0);
    chk("t3_id0", 64'(wb_inst_id[0]), 64'd7);
    fu_wb_valid[2] = 1'b0;
    step();
    chk("idle_valid0", 64'(wb_valid[0]), 64'd0);

    // flush: pointer sits at 3, grants 3,0 then flush, then resume at 1,2
    for (int i = 0; i < NF; i++) set_fu(i, 1, 6'(40 + i), 1, 6'(50 + i), 64'(i));
    step();
    chk("t5_pre_fu0", 64'(wb_fu[0]), 64'd3);
    chk("t5_pre_fu1", 64'(wb_fu[1]), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_flush_valid0", 64'(wb_valid[0]), 64'd0);
    chk("t5_flush_valid1", 64'(wb_valid[1]), 64'd0);
    step();
    chk("t5_resume_fu0", 64'(wb_fu[0]), 64'd1);
    chk("t5_resume_fu1", 64'(wb_fu[1]), 64'd2);

    // async reset while outputs are valid
    chk("t6_pre_valid", 64'(wb_valid[0]), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid0", 64'(wb_valid[0]), 64'd0);
    chk("t6_async_we1", 64'(prf_write_enable[1]), 64'd0);
    chk("t6_async_ready2", 64'(fu_wb_ready[2]), 64'd0);
    model_reset();
    step();
    rst = 1'b0;
    step();
    chk("t6_after_fu0", 64'(wb_fu[0]), 64'd0);
    chk("t6_after_fu1", 64'(wb_fu[1]), 64'd1);

    // randomized traffic; FUs hold requests until granted
    for (int c = 0; c < 400; c++) begin
      bit granted [NF];
      for (int i = 0; i < NF; i++) granted[i] = exp_ready[i];
      for (int i = 0; i < NF; i++) begin
        if (granted[i] || !fu_wb_valid[i]) begin
          if ($urandom_range(99) < 60) new_req(i);
          else fu_wb_valid[i] = 1'b0;
        end
      end
      flush = ($urandom_range(99) < 8);
      step();
    end
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the physical-register-file write ports and the PRN-ready broadcast among all functional units (FUs).
- Every FU presents one completed result per cycle with a valid/ready handshake. Up to WB_PORTS results are granted per cycle in round-robin order.
- Granted results are registered and driven to the PRF write ports, the issue-queue wakeup (set_prn_ready) and the ROB completion interface one cycle later.
- Sits between the FU outputs and the PRF/ROB, downstream of the instruction router.

Parameters:
FU_COUNT, 4, number of requesting functional units
WB_PORTS, 2, PRF write/broadcast ports granted per cycle (1 <= WB_PORTS <= FU_COUNT)
INST_ID_BITS, 6, instruction ID width
PRN_BITS, 6, physical register number width
FUC_BITS, 2, FU index width (clog2 FU_COUNT)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  pipeline flush; drop all pending and in-flight writebacks
fu_wb_valid[FU_COUNT]  in  1  FU i has a completed result
fu_wb_inst_id[FU_COUNT]  in  INST_ID_BITS  instruction ID of the result
fu_wb_prn_valid[FU_COUNT]  in  1  result writes a destination register
fu_wb_prn[FU_COUNT]  in  PRN_BITS  destination PRN
fu_wb_data[FU_COUNT]  in  64  result data
fu_wb_ready[FU_COUNT]  out  1  grant; the result transfers when valid && ready
wb_valid[WB_PORTS]  out  1  port p carries a completed instruction
wb_inst_id[WB_PORTS]  out  INST_ID_BITS  to ROB completion
wb_fu[WB_PORTS]  out  FUC_BITS  index of the source FU
prf_write_enable[WB_PORTS]  out  1  wb_valid && prn_valid
prf_write_prn[WB_PORTS]  out  PRN_BITS  PRF write address; also the set_prn broadcast
prf_write_data[WB_PORTS]  out  64  PRF write data
set_prn_ready[WB_PORTS]  out  1  wakeup broadcast; equals prf_write_enable

Behaviour:
- Reset (async, rst=1):
  - all wb_valid, prf_write_enable and set_prn_ready = 0
  - wb_inst_id, wb_fu, prf_write_prn, prf_write_data = 0
  - round-robin pointer rr_ptr = 0
  - fu_wb_ready = 0 while rst is high
- Grant (combinational, same cycle):
  - Scan FU indices rr_ptr, rr_ptr+1, ... modulo FU_COUNT.
  - Grant the first WB_PORTS requesters with fu_wb_valid=1.
  - fu_wb_ready[i]=1 only for granted i.
  - ready never depends on anything other than fu_wb_valid, rr_ptr, flush and rst.
  - The k-th grant in scan order is assigned to port k; unused ports are idle.
- Output register (latency 1):
  - On the clock edge after a grant, port k holds the granted FU's inst_id, prn, data and FU index.
  - wb_valid=1; prf_write_enable = set_prn_ready = fu_wb_prn_valid.
  - Idle ports: wb_valid=0, prf_write_enable=0; data fields hold their previous values (don't-care).
  - Outputs are valid for exactly one cycle per transfer. There is no downstream backpressure: the PRF and ROB always accept.
- Pointer update:
  - When at least one grant occurs, rr_ptr <= (index of the last granted FU + 1) mod FU_COUNT.
  - With no grants, rr_ptr is unchanged.
  - Wrap-around: last grant at FU_COUNT-1 sets rr_ptr=0.
- Fairness:
  - A requester holding fu_wb_valid is granted within ceil(FU_COUNT/WB_PORTS) cycles.
  - FUs must hold valid and payload stable until ready.
- Under-subscription: if the number of requesters is <= WB_PORTS, all are granted in the same cycle.
- Flush:
  - When flush=1, fu_wb_ready=0 for all FUs.
  - The next edge clears all wb_valid, prf_write_enable and set_prn_ready.
  - rr_ptr is unchanged.
  - A registered transfer already visible on the outputs during the flush cycle completes; flush only suppresses the following cycle.
- Simultaneous flush and valid: flush wins; no transfer occurs.
- Reset mid-operation: outputs clear immediately (async). Requests pending at reset are not granted until rst deasserts.
- Duplicate PRNs across ports in one cycle are not checked; the rename stage guarantees uniqueness.

Test Plan:
1. Reset → all 4 fu_wb_valid=1 → cycle 0 grants FU0,FU1; cycle 1 grants FU2,FU3; port0 inst_id/data match FU0 one cycle after grant; rr_ptr=0 after cycle 1.
2. Only FU3 valid (prn=5, data=0xDEAD, prn_valid=1) → ready[3]=1 same cycle; next cycle wb_valid[0]=1, prf_write_prn[0]=5, set_prn_ready[0]=1, wb_valid[1]=0.
3. FU2 valid with prn_valid=0 → wb_valid=1, prf_write_enable=0, set_prn_ready=0; ROB sees inst_id.
4. FU0 held valid continuously while FU1–FU3 request each cycle (WB_PORTS=1) → every FU granted once within 4 cycles; grant order 0,1,2,3,0.
5. Grant cycle followed by flush=1 with all FUs valid → no ready during flush; wb_valid=0 on the cycle after flush; rr_ptr preserved; the grant sequence resumes from it.
6. Assert rst asynchronously while wb_valid=1 → wb_valid drops before the next clk edge; the first grant after release starts at FU0.
